// File: rtl/axi_copy_master.sv
// rtl/axi_copy_master.sv - AXI master copying one INCR burst of up to 16 words from src to dst
module axi_copy_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        a_clk,
  input  logic        a_resetn,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [3:0]  len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  ar_id,
  output logic [31:0] ar_addr,
  output logic [3:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [3:0]  r_id,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  input  logic        r_valid,
  output logic        r_ready,
  output logic [3:0]  aw_id,
  output logic [31:0] aw_addr,
  output logic [3:0]  aw_len,
  output logic [2:0]  aw_size,
  output logic [1:0]  aw_burst,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [3:0]  w_id,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  output logic        w_last,
  output logic        w_valid,
  input  logic        w_ready,
  input  logic [3:0]  b_id,
  input  logic [1:0]  b_resp,
  input  logic        b_valid,
  output logic        b_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] src_q, src_d;
  logic [29:0] dst_q, dst_d;
  logic [3:0]  len_q, len_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        error_q, error_d;
  logic [31:0] buf_q [16];
  logic        buf_we;

  logic        ar_valid_q, aw_valid_q, w_valid_q, r_ready_q, b_ready_q;
  logic        busy_q, done_q, w_last_q;
  logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
  logic [3:0]  ar_len_q, aw_len_q, ar_id_q, aw_id_q, w_id_q;

  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        r_bad, b_bad;
  logic [10:0] src_end, dst_end;
  logic        unused_addr_lsbs;

  // Byte-lane bits of the command addresses are not meaningful for word bursts
  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  assign ar_hs = ar_valid_q && ar_ready;
  assign r_hs  = r_valid && r_ready_q;
  assign aw_hs = aw_valid_q && aw_ready;
  assign w_hs  = w_valid_q && w_ready;
  assign b_hs  = b_valid && b_ready_q;

  // Last word index inside the 4 KB page; bit 10 set means the burst leaves the page
  assign src_end = {1'b0, src_q[9:0]} + {7'd0, len_q};
  assign dst_end = {1'b0, dst_q[9:0]} + {7'd0, len_q};

  // A read beat is bad on slave error, foreign ID, or r_last arriving on the wrong beat
  assign r_bad = (r_resp != 2'b00) || (r_id != AXI_ID) ||
                 (r_last && (cnt_q != {1'b0, len_q}));
  assign b_bad = (b_resp != 2'b00) || (b_id != AXI_ID);

  // State and command registers
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Next-state logic: read burst into the buffer, then drain it as a write burst
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    buf_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr[31:2];
          dst_d   = dst_addr[31:2];
          len_d   = len;
          cnt_d   = '0;
          error_d = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (src_end[10] || dst_end[10]) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (ar_hs) state_d = ST_R;
      end
      ST_R: begin
        if (r_hs) begin
          // cnt saturates at 16 so surplus beats are dropped, not wrapped
          if (!cnt_q[4]) begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + 5'd1;
          end
          if (r_bad) error_d = 1'b1;
          if (r_last) begin
            if (error_q || r_bad) begin
              state_d = ST_DONE;
            end else begin
              cnt_d   = '0;
              state_d = ST_AW;
            end
          end
        end
      end
      ST_AW: begin
        if (aw_hs) state_d = ST_W;
      end
      ST_W: begin
        if (w_hs) begin
          if (w_last_q) state_d = ST_B;
          else          cnt_d   = cnt_q + 5'd1;
        end
      end
      ST_B: begin
        if (b_hs) begin
          if (b_bad) error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Copy buffer; contents are only read after being written, so no reset is needed
  always_ff @(posedge a_clk) begin
    if (buf_we) buf_q[cnt_q[3:0]] <= r_data;
  end

  // Registered bus outputs, derived from the state being entered
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_last_q   <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_id_q    <= '0;
      w_id_q     <= '0;
      w_data_q   <= '0;
    end else begin
      ar_valid_q <= (state_d == ST_AR);
      aw_valid_q <= (state_d == ST_AW);
      w_valid_q  <= (state_d == ST_W);
      r_ready_q  <= (state_d == ST_R);
      b_ready_q  <= (state_d == ST_B);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      if (state_q == ST_CHECK && state_d == ST_AR) begin
        ar_addr_q <= {src_q, 2'b00};
        ar_len_q  <= len_q;
        ar_id_q   <= AXI_ID;
      end
      if (state_q == ST_R && state_d == ST_AW) begin
        aw_addr_q <= {dst_q, 2'b00};
        aw_len_q  <= len_q;
        aw_id_q   <= AXI_ID;
      end
      if (state_q == ST_AW && state_d == ST_W) w_id_q <= AXI_ID;
      // Data for the beat that will be on the bus next cycle; unchanged while stalled
      if (state_d == ST_W) begin
        w_data_q <= buf_q[cnt_d[3:0]];
        w_last_q <= (cnt_d[3:0] == len_q);
      end else begin
        w_last_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign ar_id    = ar_id_q;
  assign ar_addr  = ar_addr_q;
  assign ar_len   = ar_len_q;
  assign ar_size  = 3'b010;
  assign ar_burst = 2'b01;
  assign ar_valid = ar_valid_q;
  assign r_ready  = r_ready_q;
  assign aw_id    = aw_id_q;
  assign aw_addr  = aw_addr_q;
  assign aw_len   = aw_len_q;
  assign aw_size  = 3'b010;
  assign aw_burst = 2'b01;
  assign aw_valid = aw_valid_q;
  assign w_id     = w_id_q;
  assign w_data   = w_data_q;
  assign w_strb   = 4'hF;
  assign w_last   = w_last_q;
  assign w_valid  = w_valid_q;
  assign b_ready  = b_ready_q;

endmodule

// File: tb/tb_axi_copy_master.sv
// tb/tb_axi_copy_master.sv - table-driven bench for axi_copy_master with a reactive AXI slave memory
module tb_axi_copy_master;

  logic        a_clk, a_resetn, start;
  logic [31:0] src_addr, dst_addr;
  logic [3:0]  len;
  logic        busy, done, error;
  logic [3:0]  ar_id, ar_len, r_id, aw_id, aw_len, w_id, w_strb, b_id;
  logic [31:0] ar_addr, r_data, aw_addr, w_data;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready, aw_valid, aw_ready;
  logic        w_last, w_valid, w_ready, b_valid, b_ready;

  axi_copy_master dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .error(error),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [3:0]  len;
    int          err_beat;
    logic [1:0]  bresp;
    bit          stall;
    bit          pulse;
    bit          exp_err;
    bit          exp_rd;
    bit          exp_wr;
    int          exp_done;
  } vec_t;

  vec_t vecs [10];

  int checks = 0;
  int errors = 0;
  int cur_row = 0;

  logic [31:0] mem [4096];
  logic [31:0] exp_q [16];
  bit          cfg_stall;
  int          cfg_err_beat;
  logic [1:0]  cfg_bresp;
  logic [3:0]  cfg_len;
  logic [31:0] cfg_src, cfg_dst;
  int          ar_n, ar_seen, aw_seen, w_n;

  logic        hs_ar, hs_r, hs_aw, hs_w, hs_b, hold_ar, hold_aw, hold_w;
  logic [31:0] s_ar_addr, s_aw_addr, s_w_data;
  logic [3:0]  s_ar_len, s_aw_len;
  logic        s_w_last, s_r_last;
  bit          rd_pend, wr_pend, b_pend;
  int          rd_beat, wr_beat;
  logic [31:0] rd_addr, wr_addr;
  logic [3:0]  rd_len;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL r%0d %s: got %0h expected %0h", cur_row, name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a, input int i);
    return (int'(a[13:2]) + i) & 4095;
  endfunction

  function automatic logic rnd_ready();
    return cfg_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
  endfunction

  // Slave: apply handshakes from the last rising edge, then drive the next half cycle
  always @(negedge a_clk) begin
    if (!a_resetn) begin
      rd_pend = 0; wr_pend = 0; b_pend = 0;
      hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
      hold_ar = 0; hold_aw = 0; hold_w = 0;
      ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; b_valid = 0;
      r_last = 0; r_data = 0; r_resp = 0; r_id = 0; b_id = 0; b_resp = 0;
    end else begin
      if (hold_ar) check("ar_stable", {ar_valid, ar_addr, ar_len}, {1'b1, s_ar_addr, s_ar_len});
      if (hold_aw) check("aw_stable", {aw_valid, aw_addr, aw_len}, {1'b1, s_aw_addr, s_aw_len});
      if (hold_w)  check("w_stable", {w_valid, w_data, w_last}, {1'b1, s_w_data, s_w_last});
      if (hs_ar) begin
        ar_n++;
        check("ar_addr", s_ar_addr, {cfg_src[31:2], 2'b00});
        check("ar_len", s_ar_len, cfg_len);
        rd_pend = 1; rd_addr = s_ar_addr; rd_len = s_ar_len; rd_beat = 0;
      end
      if (hs_r) begin
        r_valid = 0;
        rd_beat++;
        if (s_r_last) rd_pend = 0;
      end
      if (hs_aw) begin
        check("aw_addr", s_aw_addr, {cfg_dst[31:2], 2'b00});
        check("aw_len", s_aw_len, cfg_len);
        wr_pend = 1; wr_addr = s_aw_addr; wr_beat = 0;
      end
      if (hs_w) begin
        w_n++;
        check("w_data", s_w_data, exp_q[wr_beat & 15]);
        check("w_last", s_w_last, wr_beat == int'(cfg_len));
        mem[widx(wr_addr, wr_beat)] = s_w_data;
        wr_beat++;
        if (s_w_last) begin wr_pend = 0; b_pend = 1; end
      end
      if (hs_b) begin b_valid = 0; b_pend = 0; end

      ar_ready = rnd_ready();
      aw_ready = rnd_ready();
      w_ready  = rnd_ready();
      if (rd_pend && !r_valid) begin
        r_valid = rnd_ready();
        r_id    = 4'h0;
        r_data  = mem[widx(rd_addr, rd_beat)];
        r_last  = (rd_beat == int'(rd_len));
        r_resp  = (rd_beat == cfg_err_beat) ? 2'b10 : 2'b00;
      end
      if (b_pend && !b_valid) begin
        b_valid = rnd_ready();
        b_id    = 4'h0;
        b_resp  = cfg_bresp;
      end
      if (ar_valid) ar_seen++;
      if (aw_valid) aw_seen++;

      hs_ar = ar_valid && ar_ready;  hold_ar = ar_valid && !ar_ready;
      s_ar_addr = ar_addr;           s_ar_len = ar_len;
      hs_aw = aw_valid && aw_ready;  hold_aw = aw_valid && !aw_ready;
      s_aw_addr = aw_addr;           s_aw_len = aw_len;
      hs_w = w_valid && w_ready;     hold_w = w_valid && !w_ready;
      s_w_data = w_data;             s_w_last = w_last;
      hs_r = r_valid && r_ready;     s_r_last = r_last;
      hs_b = b_valid && b_ready;
    end
  end

  task automatic prep(input vec_t v, input int row);
    cur_row = row;
    cfg_stall = v.stall; cfg_err_beat = v.err_beat; cfg_bresp = v.bresp;
    cfg_len = v.len; cfg_src = v.src; cfg_dst = v.dst;
    ar_n = 0; ar_seen = 0; aw_seen = 0; w_n = 0;
    for (int i = 0; i < 16; i++) begin
      exp_q[i] = (32'(row) << 24) | (32'h11 * 32'(i + 1));
      mem[widx(v.src, i)] = exp_q[i];
      mem[widx(v.dst, i)] = 32'hDEAD0000 | 32'(i);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge a_clk);
    src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
    @(posedge a_clk);
    @(negedge a_clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int row);
    int cyc;
    int done_cyc;
    prep(v, row);
    issue(v);
    cyc = 1;
    check("busy_c1", busy, 1'b1);
    check("err_clr", error, 1'b0);
    done_cyc = -1;
    while (cyc < 400) begin
      if (done) begin done_cyc = cyc; break; end
      start = v.pulse && (cyc == 4);
      @(posedge a_clk);
      cyc++;
      @(negedge a_clk);
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL r%0d done_timeout: got no done expected done within 400 cycles", row);
    end else begin
      if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
      check("error", error, v.exp_err);
      check("busy_at_done", busy, 1'b1);
      @(posedge a_clk);
      @(negedge a_clk);
      check("done_pulse", {done, busy}, 2'b00);
      repeat (3) @(negedge a_clk);
      check("ar_count", ar_n, v.exp_rd ? 1 : 0);
      check("ar_seen", ar_seen != 0, v.exp_rd);
      check("aw_seen", aw_seen != 0, v.exp_wr);
      check("idle_busy", busy, 1'b0);
      if (v.exp_wr) begin
        check("w_beats", w_n, int'(v.len) + 1);
        for (int i = 0; i <= int'(v.len); i++)
          check($sformatf("mem%0d", i), mem[widx(v.dst, i)], exp_q[i]);
      end
    end
  endtask

  initial begin
    //           src           dst           len  eb  bresp stl pls err rd wr done
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 4'd3,  -1, 2'b00, 0, 0, 0, 1, 1, 13};
    vecs[1] = '{32'h0000_0400, 32'h0000_0800, 4'd15, -1, 2'b00, 1, 0, 0, 1, 1, -1};
    vecs[2] = '{32'h0000_0FF8, 32'h0000_0200, 4'd3,  -1, 2'b00, 0, 0, 1, 0, 0, 2};
    vecs[3] = '{32'h0000_0100, 32'h0000_0600, 4'd3,   1, 2'b00, 0, 0, 1, 1, 0, 7};
    vecs[4] = '{32'h0000_0900, 32'h0000_0A00, 4'd3,  -1, 2'b00, 0, 0, 0, 1, 1, 13};
    vecs[5] = '{32'h0000_0B00, 32'h0000_0C00, 4'd3,  -1, 2'b11, 0, 1, 1, 1, 1, 13};
    vecs[6] = '{32'h0000_0D00, 32'h0000_0E00, 4'd0,  -1, 2'b00, 0, 0, 0, 1, 1, 7};
    vecs[7] = '{32'h0000_1FC0, 32'h0000_2000, 4'd15, -1, 2'b00, 0, 0, 0, 1, 1, 37};
    vecs[8] = '{32'h0000_3000, 32'h0000_1FFC, 4'd1,  -1, 2'b00, 0, 0, 1, 0, 0, 2};
    vecs[9] = '{32'h0000_2400, 32'h0000_2C00, 4'd7,  -1, 2'b00, 0, 0, 0, 1, 1, 21};

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    a_resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    cfg_stall = 0; cfg_err_beat = -1; cfg_bresp = 2'b00; cfg_len = '0;
    cfg_src = '0; cfg_dst = '0;
    repeat (3) @(negedge a_clk);
    check("reset_outs",
          {ar_valid, aw_valid, w_valid, r_ready, b_ready, busy, done, error, w_last,
           ar_addr, ar_len, ar_id, aw_addr, aw_len, aw_id, w_id, w_data}, '0);
    check("consts", {ar_size, aw_size, ar_burst, aw_burst, w_strb},
          {3'b010, 3'b010, 2'b01, 2'b01, 4'hF});
    #2 a_resetn = 1'b1;

    for (int r = 0; r < 9; r++) run_vec(vecs[r], r);

    // Reset in the middle of the write burst, then a clean copy afterwards
    begin
      vec_t vi;
      int   n;
      bit   seen;
      vi = '{32'h0000_2400, 32'h0000_2800, 4'd7, -1, 2'b00, 0, 0, 0, 1, 1, -1};
      prep(vi, 10);
      issue(vi);
      seen = 0;
      n = 0;
      while (n < 100 && !seen) begin
        @(negedge a_clk);
        seen = w_valid;
        n++;
      end
      check("w_reached", seen, 1'b1);
      @(negedge a_clk);
      #2 a_resetn = 1'b0;
      #1 check("async_rst_outs",
               {ar_valid, aw_valid, w_valid, r_ready, b_ready, busy, done, error, w_last,
                ar_addr, ar_len, ar_id, aw_addr, aw_len, aw_id, w_id, w_data}, '0);
      repeat (2) @(negedge a_clk);
      #2 a_resetn = 1'b1;
    end
    run_vec(vecs[9], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
